timing_multi: RTL and testbench
===============================

Name: timing_multi

Overview:
- Parametrised successor to the single-channel timer: NUM_CH independent timer channels with CNT_W-bit counters.
- Each channel has per-channel start/halt triggers, continuous or one-shot mode, a terminal count, a status flag, a live count readout and a one-cycle interrupt pulse.
- A shared tick enable is generated by an optional prescaler.
- Sits behind the register block: ro_* inputs come from register outputs, rf_* outputs feed register-file readback and the interrupt controller.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- CNT_W, 32, counter and terminal-count width per channel.
- PRE_W, 16, prescaler compare width (used only when the prescaler is compiled in).

Ports:
- clk  input  1  master clock.
- reset  input  1  synchronous, active-low reset: sampled on posedge clk, asserted when 0.
- ro_trig_start  input  NUM_CH  per-channel start request; a one-cycle pulse or a level, sampled each clk.
- ro_trig_halt  input  NUM_CH  per-channel halt request, sampled each clk.
- ro_mode  input  NUM_CH  per channel: 1 = continuous, 0 = one-shot.
- ro_termcount  input  NUM_CH*CNT_W  terminal counts; channel i occupies bits [i*CNT_W +: CNT_W].
- ro_prescale  input  PRE_W  prescaler compare value.
- rf_status  output  NUM_CH  per channel: 1 = running.
- rf_currcount  output  NUM_CH*CNT_W  live counts, packed the same way as ro_termcount.
- rf_int  output  NUM_CH  per-channel interrupt pulse.
- rf_int_any  output  1  OR of rf_int.

Behaviour:
- All logic is in a single always @(posedge clk) domain; there are no edge-triggered trigger inputs.
- Reset (reset==0) clears all outputs to 0 and the prescaler counter to 0, and overrides every other event, including mid-count.
- tick: with the prescaler compiled out, tick=1 every cycle (see Optional Feature).
- Per-channel state is the status bit: IDLE (0) and RUN (1). Priority per cycle, highest first: reset > halt > start > count.
- Halt (ro_trig_halt[i]=1), in any state: status←0, currcount←0. No interrupt is generated, even if terminal is hit in the same cycle.
- Start in IDLE: status←1, currcount←0. Counting begins on the next tick. Start in RUN is ignored and does not restart the channel.
- RUN on a cycle with tick=1:
  - If currcount==termcount: terminal event.
    - Continuous: currcount←0, status stays 1.
    - One-shot: status←0, currcount holds termcount.
  - Otherwise: currcount←currcount+1, CNT_W-bit, wrapping modulo 2^CNT_W.
- RUN on a cycle with tick=0: hold.
- Interrupt: rf_int[i] is registered and is 1 for exactly the one cycle after the terminal-event edge; otherwise it is 0.
  - Back-to-back terminals (termcount=0, continuous, tick every cycle) keep rf_int[i] high continuously, one pulse per terminal.
- Period: the interrupt period is (termcount+1) ticks. termcount=0 means a terminal on every tick.
- termcount change while running: the comparison uses the live ro_termcount. If the new value is below currcount, the counter runs to 2^CNT_W-1, wraps to 0, then hits the terminal. This is intended and is not an error.
- Channels are fully independent. Simultaneous events on different channels all take effect in the same cycle.
- rf_int_any is combinational OR of the registered rf_int.

Optional Feature:
- Macro: TIMING_PRESCALE_EN.
- Defined:
  - A shared PRE_W-bit prescaler counter increments every cycle.
  - When the counter equals ro_prescale, tick=1 and the counter←0; otherwise tick=0.
  - Result: tick fires every (ro_prescale+1) cycles; ro_prescale=0 gives tick every cycle.
  - The prescaler free-runs regardless of channel status and is cleared only by reset.
- Not defined: tick is tied to 1, ro_prescale is ignored (port still present), and no prescaler flops are built.

Test Plan:
- Reset low for 3 cycles with random inputs → all rf_* = 0. Release, then start ch0 with mode=1, termcount=4 → rf_int[0] pulses one cycle every 5 cycles; currcount sequence is 0,1,2,3,4,0.
- One-shot ch1, termcount=3 → a single rf_int[1] pulse; rf_status[1]=0 and rf_currcount=3 afterward; a further start restarts from 0.
- Start and halt in the same cycle on ch2 → status stays 0, count stays 0. Halt on the cycle where currcount==termcount → no rf_int, count=0.
- Continuous, termcount=0 → rf_int high every cycle after the first. Lower termcount from 10 to 2 while currcount=5 (CNT_W=4 build) → count wraps through 15→0, then the terminal at 2.
- All 4 channels with termcounts 1, 2, 3, 4 started together → independent pulse trains; rf_int_any equals OR of rf_int. Assert reset mid-run → everything clears next cycle.
- TIMING_PRESCALE_EN defined, ro_prescale=2, termcount=1, continuous → rf_int every 6 cycles. Undefined build with the same stimulus → rf_int every 2 cycles.

Source files
------------

// File: rtl/timing_multi.sv
// Multi-channel timer: NUM_CH independent CNT_W-bit counters sharing one tick; optional prescaler under TIMING_PRESCALE_EN.
// Latency: triggers take effect on the next clk edge; rf_int is registered one cycle after the terminal event.
// Backpressure: none; every input is sampled each cycle, and halt overrides start and count.
module timing_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ro_trig_start,
    input  logic [NUM_CH-1:0]       ro_trig_halt,
    input  logic [NUM_CH-1:0]       ro_mode,
    input  logic [NUM_CH*CNT_W-1:0] ro_termcount,
    input  logic [PRE_W-1:0]        ro_prescale,
    output logic [NUM_CH-1:0]       rf_status,
    output logic [NUM_CH*CNT_W-1:0] rf_currcount,
    output logic [NUM_CH-1:0]       rf_int,
    output logic                    rf_int_any
);

    logic                         tick;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0] term;

`ifdef TIMING_PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt;

    // Free-running and shared by all channels; only reset clears it.
    assign tick = (pre_cnt == ro_prescale);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end
`else
    logic unused_prescale;

    assign tick            = 1'b1;
    assign unused_prescale = ^ro_prescale;
`endif

    assign term         = ro_termcount;
    assign rf_currcount = cnt_q;
    assign rf_int_any   = |rf_int;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_status <= '0;
            rf_int    <= '0;
            cnt_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                rf_int[i] <= 1'b0;
                if (ro_trig_halt[i]) begin
                    rf_status[i] <= 1'b0;
                    cnt_q[i]     <= '0;
                end else if (ro_trig_start[i] && !rf_status[i]) begin
                    rf_status[i] <= 1'b1;
                    cnt_q[i]     <= '0;
                end else if (rf_status[i] && tick) begin
                    // Live termcount compare: lowering it below the count makes the counter wrap first.
                    if (cnt_q[i] == term[i]) begin
                        rf_int[i] <= 1'b1;
                        if (ro_mode[i]) begin
                            cnt_q[i] <= '0;
                        end else begin
                            rf_status[i] <= 1'b0;
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timing_multi.sv
// Directed bench for timing_multi (NUM_CH=4, CNT_W=4); expected values are hand-derived per step.
module tb_timing_multi;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int PW  = 16;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    ro_trig_start;
    logic [NCH-1:0]    ro_trig_halt;
    logic [NCH-1:0]    ro_mode;
    logic [NCH*CW-1:0] ro_termcount;
    logic [PW-1:0]     ro_prescale;
    logic [NCH-1:0]    rf_status;
    logic [NCH*CW-1:0] rf_currcount;
    logic [NCH-1:0]    rf_int;
    logic              rf_int_any;

    int errors = 0;
    int checks = 0;

    timing_multi #(.NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ro_trig_start(ro_trig_start),
        .ro_trig_halt (ro_trig_halt),
        .ro_mode      (ro_mode),
        .ro_termcount (ro_termcount),
        .ro_prescale  (ro_prescale),
        .rf_status    (rf_status),
        .rf_currcount (rf_currcount),
        .rf_int       (rf_int),
        .rf_int_any   (rf_int_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return rf_currcount[ch*CW +: CW];
    endfunction

    task automatic set_term(input int ch, input int val);
        ro_termcount[ch*CW +: CW] = CW'(val);
    endtask

    initial begin
        int ecnt;
        int eint;
        int first_seen;
        int gap;
        logic [NCH-1:0] eint_v;

        // Reset with random inputs
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ro_trig_start = 4'($urandom);
            ro_trig_halt  = 4'($urandom);
            ro_mode       = 4'($urandom);
            ro_termcount  = 16'($urandom);
            ro_prescale   = 16'($urandom);
            step();
        end
        chk("rst_status", 32'(rf_status), 32'h0);
        chk("rst_count", 32'(rf_currcount), 32'h0);
        chk("rst_int", 32'(rf_int), 32'h0);
        chk("rst_int_any", 32'(rf_int_any), 32'h0);

        reset         = 1'b1;
        ro_trig_start = '0;
        ro_trig_halt  = '0;
        ro_mode       = '0;
        ro_termcount  = '0;
        ro_prescale   = '0;
        step();
        chk("idle_status", 32'(rf_status), 32'h0);

        // ch0 continuous, termcount 4: counts 0..4 then wraps with a pulse
        ro_mode[0] = 1'b1;
        set_term(0, 4);
        ro_trig_start[0] = 1'b1;
        step();
        ro_trig_start[0] = 1'b0;
        chk("c0_start_status", 32'(rf_status[0]), 32'h1);
        chk("c0_start_cnt", 32'(cnt_of(0)), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("c0_cnt", 32'(cnt_of(0)), 32'(k % 5));
            chk("c0_int", 32'(rf_int[0]), 32'((k % 5) == 0));
            chk("c0_int_any", 32'(rf_int_any), 32'((k % 5) == 0));
        end
        ro_trig_halt[0] = 1'b1;
        step();
        ro_trig_halt[0] = 1'b0;
        chk("c0_halt_status", 32'(rf_status[0]), 32'h0);
        chk("c0_halt_cnt", 32'(cnt_of(0)), 32'h0);

        // ch1 one-shot, termcount 3
        ro_mode[1] = 1'b0;
        set_term(1, 3);
        ro_trig_start[1] = 1'b1;
        step();
        ro_trig_start[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("os_cnt", 32'(cnt_of(1)), 32'(k));
            chk("os_int_low", 32'(rf_int[1]), 32'h0);
        end
        step();
        chk("os_int_pulse", 32'(rf_int[1]), 32'h1);
        chk("os_done_status", 32'(rf_status[1]), 32'h0);
        chk("os_done_cnt", 32'(cnt_of(1)), 32'h3);
        step();
        chk("os_int_single", 32'(rf_int[1]), 32'h0);
        chk("os_hold_cnt", 32'(cnt_of(1)), 32'h3);
        ro_trig_start[1] = 1'b1;
        step();
        ro_trig_start[1] = 1'b0;
        chk("os_restart_status", 32'(rf_status[1]), 32'h1);
        chk("os_restart_cnt", 32'(cnt_of(1)), 32'h0);
        // Start while running is ignored
        ro_trig_start[1] = 1'b1;
        step();
        ro_trig_start[1] = 1'b0;
        chk("os_start_in_run", 32'(cnt_of(1)), 32'h1);
        ro_trig_halt[1] = 1'b1;
        step();
        ro_trig_halt[1] = 1'b0;

        // ch2 start+halt together, then halt on terminal
        ro_trig_start[2] = 1'b1;
        ro_trig_halt[2]  = 1'b1;
        step();
        ro_trig_start[2] = 1'b0;
        ro_trig_halt[2]  = 1'b0;
        chk("sh_status", 32'(rf_status[2]), 32'h0);
        chk("sh_cnt", 32'(cnt_of(2)), 32'h0);
        ro_mode[2] = 1'b1;
        set_term(2, 2);
        ro_trig_start[2] = 1'b1;
        step();
        ro_trig_start[2] = 1'b0;
        step();
        step();
        chk("ht_at_term", 32'(cnt_of(2)), 32'h2);
        ro_trig_halt[2] = 1'b1;
        step();
        ro_trig_halt[2] = 1'b0;
        chk("ht_no_int", 32'(rf_int[2]), 32'h0);
        chk("ht_cnt", 32'(cnt_of(2)), 32'h0);
        chk("ht_status", 32'(rf_status[2]), 32'h0);

        // ch3 continuous termcount 0: rf_int stays high
        ro_mode[3] = 1'b1;
        set_term(3, 0);
        ro_trig_start[3] = 1'b1;
        step();
        ro_trig_start[3] = 1'b0;
        chk("t0_first_int", 32'(rf_int[3]), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t0_int", 32'(rf_int[3]), 32'h1);
            chk("t0_cnt", 32'(cnt_of(3)), 32'h0);
        end
        ro_trig_halt[3] = 1'b1;
        step();
        ro_trig_halt[3] = 1'b0;

        // ch0 termcount lowered 10 -> 2 at count 5: wraps through 15 -> 0
        ro_mode[0] = 1'b1;
        set_term(0, 10);
        ro_trig_start[0] = 1'b1;
        step();
        ro_trig_start[0] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("wr_at5", 32'(cnt_of(0)), 32'h5);
        set_term(0, 2);
        for (int k = 0; k < 10; k++) step();
        chk("wr_at15", 32'(cnt_of(0)), 32'hf);
        chk("wr_no_int15", 32'(rf_int[0]), 32'h0);
        step();
        chk("wr_wrap0", 32'(cnt_of(0)), 32'h0);
        chk("wr_no_int0", 32'(rf_int[0]), 32'h0);
        step();
        step();
        chk("wr_at2", 32'(cnt_of(0)), 32'h2);
        step();
        chk("wr_term_int", 32'(rf_int[0]), 32'h1);
        chk("wr_term_cnt", 32'(cnt_of(0)), 32'h0);
        ro_trig_halt[0] = 1'b1;
        step();
        ro_trig_halt[0] = 1'b0;

        // All channels, termcounts 1..4, started together
        ro_mode = 4'hf;
        for (int c = 0; c < NCH; c++) set_term(c, c + 1);
        ro_trig_start = 4'hf;
        step();
        ro_trig_start = 4'h0;
        chk("all_status", 32'(rf_status), 32'hf);
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                eint_v[c] = ((k % (c + 2)) == 0);
                chk("all_cnt", 32'(cnt_of(c)), 32'(k % (c + 2)));
            end
            chk("all_int", 32'(rf_int), 32'(eint_v));
            chk("all_int_any", 32'(rf_int_any), 32'(|eint_v));
        end
        reset = 1'b0;
        step();
        chk("mid_rst_status", 32'(rf_status), 32'h0);
        chk("mid_rst_cnt", 32'(rf_currcount), 32'h0);
        chk("mid_rst_int", 32'(rf_int), 32'h0);
        reset = 1'b1;
        ro_mode = '0;
        ro_termcount = '0;
        step();

        // Prescale 2, termcount 1, continuous: pulse spacing depends on build
        ro_prescale = 16'd2;
        ro_mode[0]  = 1'b1;
        set_term(0, 1);
        ro_trig_start[0] = 1'b1;
        step();
        ro_trig_start[0] = 1'b0;
        first_seen = 0;
        gap = 0;
        ecnt = 0;
        eint = 0;
        for (int n = 0; n < 60 && eint == 0; n++) begin
            step();
            if (first_seen != 0) gap++;
            if (rf_int[0]) begin
                if (first_seen != 0) eint = 1;
                first_seen = 1;
            end
        end
        chk("ps_pulses_seen", 32'(eint), 32'h1);
`ifdef TIMING_PRESCALE_EN
        ecnt = 6;
`else
        ecnt = 2;
`endif
        chk("ps_period", 32'(gap), 32'(ecnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
